dec_scheduler: RTL

DEC_SCHEDULER -- requirements
Module: dec_scheduler

---
 rtl/dec_pkg.sv | 19 +
 rtl/dec_fifo.sv | 64 ++++++
 rtl/dec_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared constants for the decryption scheduler: cipher select codes, the default
// end-of-message token and the scheduler FSM state encoding.
package dec_pkg;

   localparam logic [1:0] SEL_CAESAR  = 2'b00;
   localparam logic [1:0] SEL_SCYTALE = 2'b01;
   localparam logic [1:0] SEL_ZIGZAG  = 2'b10;
   localparam logic [1:0] SEL_INVALID = 2'b11;

   localparam logic [7:0] TOKEN_DEFAULT = 8'hFA;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE       = 2'd0;
   localparam state_t ST_FWD        = 2'd1;
   localparam state_t ST_WAIT_START = 2'd2;
   localparam state_t ST_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/dec_fifo.sv
// Input byte buffer for the scheduler: power-of-two depth, show-ahead read data,
// synchronous active-high reset. Pushes when full and pops when empty are ignored.
module dec_fifo #(
   parameter int unsigned  D_WIDTH = 8,
   parameter int unsigned  DEPTH   = 4,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned CW      = AW + 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic [D_WIDTH-1:0] wdata_i,
   input  logic               pop_i,
   output logic [D_WIDTH-1:0] rdata_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [CW-1:0]      count_o
);

   logic [D_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointers are exactly AW bits wide, so natural overflow is the modulo-DEPTH wrap.
   always_comb begin
      wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/dec_scheduler.sv
// Decryption scheduler: buffers bytes, routes each TOKEN-terminated message to the
// selected decryptor and waits for it to finish. DEC_SCHEDULER_MSG_COUNT_EN adds msg_count_o.
module dec_scheduler
   import dec_pkg::*;
#(
   parameter int unsigned        D_WIDTH    = 8,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [D_WIDTH-1:0] TOKEN      = D_WIDTH'(TOKEN_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         select_i,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               busy0_i,
   input  logic               busy1_i,
   input  logic               busy2_i,
   output logic [1:0]         select_o,
   output logic [D_WIDTH-1:0] data_o,
   output logic               valid_o,
   output logic               ovf_o,
   output logic               bad_sel_o
`ifdef DEC_SCHEDULER_MSG_COUNT_EN
   ,
   output logic [15:0]        msg_count_o
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [D_WIDTH-1:0] fifo_rdata;
   logic               fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0]      fifo_count;

   state_t             state_q, state_d;
   logic [1:0]         sel_q, sel_d, cur_sel;
   logic [D_WIDTH-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               ovf_q, ovf_d;
   logic               bad_q, bad_d;
   logic               busy_sel, msg_done;

   // rst_n is active-high: the name is inherited from the surrounding system.
   dec_fifo #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .push_i  (valid_i),
      .wdata_i (data_i),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ready_o = ~fifo_full;

   always_comb begin
      case (sel_q)
         SEL_CAESAR:  busy_sel = busy0_i;
         SEL_SCYTALE: busy_sel = busy1_i;
         SEL_ZIGZAG:  busy_sel = busy2_i;
         default:     busy_sel = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      bad_d    = 1'b0;
      fifo_pop = 1'b0;
      msg_done = 1'b0;
      ovf_d    = ovf_q | (valid_i & fifo_full);
      // The select is only sampled for the first byte of a message.
      cur_sel  = (state_q == ST_IDLE) ? select_i : sel_q;
      case (state_q)
         ST_IDLE, ST_FWD: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sel_d    = cur_sel;
               if (cur_sel == SEL_INVALID) begin
                  bad_d   = (fifo_rdata == TOKEN);
                  state_d = (fifo_rdata == TOKEN) ? ST_IDLE : ST_FWD;
               end else begin
                  valid_d = 1'b1;
                  data_d  = fifo_rdata;
                  state_d = (fifo_rdata == TOKEN) ? ST_WAIT_START : ST_FWD;
               end
            end
         end
         ST_WAIT_START: begin
            if (busy_sel) state_d = ST_WAIT_DONE;
         end
         default: begin
            if (!busy_sel) begin
               state_d  = ST_IDLE;
               msg_done = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_CAESAR;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         bad_q   <= bad_d;
      end
   end

   assign select_o  = sel_q;
   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign ovf_o     = ovf_q;
   assign bad_sel_o = bad_q;

`ifdef DEC_SCHEDULER_MSG_COUNT_EN
   logic [15:0] msg_count_q, msg_count_d;

   assign msg_count_d = msg_count_q + 16'(msg_done);
   assign msg_count_o = msg_count_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         msg_count_q <= '0;
      end else begin
         msg_count_q <= msg_count_d;
      end
   end
`else
   logic unused_msg_done;
   assign unused_msg_done = msg_done;
`endif

   fifo_full_matches_count: assert property (@(posedge clk) disable iff (rst_n)
      fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule
